// File: rtl/regfile_dump_pkg.sv
// rtl/regfile_dump_pkg.sv - shared constants and state encoding for the register-file dump reader
package regfile_dump_pkg;

   localparam int DUMP_DATA_W = 32;
   localparam int DUMP_ADDR_W = 5;
   localparam int DUMP_N_REGS = 32;

`ifdef REGFILE_DUMP_CHECKSUM_EN
   localparam int STATE_W = 3;
   localparam logic [STATE_W-1:0] SUM = 3'd4;
`else
   localparam int STATE_W = 2;
`endif

   localparam logic [STATE_W-1:0] IDLE = STATE_W'(0);
   localparam logic [STATE_W-1:0] READ = STATE_W'(1);
   localparam logic [STATE_W-1:0] SEND = STATE_W'(2);
   localparam logic [STATE_W-1:0] DONE = STATE_W'(3);

endpackage

// File: rtl/regfile_dump_reader_addr_counter.sv
// rtl/regfile_dump_reader_addr_counter.sv - loadable modulo-N_REGS address counter with end-of-range flag
module dump_addr_counter #(
   parameter int ADDR_W = 5,
   parameter int N_REGS = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              load,
   input  logic [ADDR_W-1:0] load_value,
   input  logic              inc,
   input  logic [ADDR_W-1:0] end_value,
   output logic [ADDR_W-1:0] count,
   output logic              at_end
);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count <= '0;
      end else if (load) begin
         count <= load_value;
      end else if (inc) begin
         count <= (count == ADDR_W'(N_REGS - 1)) ? '0 : count + 1'b1;
      end
   end

   assign at_end = (count == end_value);

endmodule

// File: rtl/regfile_dump_reader.sv
// rtl/regfile_dump_reader.sv - walks a register range through one read port and streams it out; REGFILE_DUMP_CHECKSUM_EN adds an XOR checksum beat
module regfile_dump_reader
   import regfile_dump_pkg::*;
#(
   parameter int DATA_W = DUMP_DATA_W,
   parameter int ADDR_W = DUMP_ADDR_W,
   parameter int N_REGS = DUMP_N_REGS
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start_i,
   input  logic [ADDR_W-1:0] first_reg_i,
   input  logic [ADDR_W-1:0] last_reg_i,
   output logic [ADDR_W-1:0] rf_read_addr_o,
   input  logic [DATA_W-1:0] rf_read_data_i,
   output logic              dump_valid_o,
   input  logic              dump_ready_i,
   output logic [ADDR_W-1:0] dump_addr_o,
   output logic [DATA_W-1:0] dump_data_o,
   output logic              dump_last_o,
   output logic              busy_o,
   output logic              done_o
`ifdef REGFILE_DUMP_CHECKSUM_EN
   ,output logic             dump_sum_o
`endif
);

   logic [STATE_W-1:0] state;
   logic [ADDR_W-1:0]  end_addr;
   logic [ADDR_W-1:0]  cur_addr;
   logic               at_end;
   logic               cnt_load;
   logic               cnt_inc;
`ifdef REGFILE_DUMP_CHECKSUM_EN
   logic [DATA_W-1:0]  sum_acc;
`endif

   assign cnt_load = (state == IDLE) && start_i;
   assign cnt_inc  = (state == SEND) && dump_ready_i && !at_end;

   dump_addr_counter #(
      .ADDR_W (ADDR_W),
      .N_REGS (N_REGS)
   ) u_addr_counter (
      .clk        (clk),
      .reset      (reset),
      .load       (cnt_load),
      .load_value (first_reg_i),
      .inc        (cnt_inc),
      .end_value  (end_addr),
      .count      (cur_addr),
      .at_end     (at_end)
   );

   // Read port is only driven during the single READ cycle; parked at 0 otherwise.
   assign rf_read_addr_o = (state == READ) ? cur_addr : '0;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state        <= IDLE;
         end_addr     <= '0;
         dump_valid_o <= 1'b0;
         dump_addr_o  <= '0;
         dump_data_o  <= '0;
         dump_last_o  <= 1'b0;
         busy_o       <= 1'b0;
         done_o       <= 1'b0;
`ifdef REGFILE_DUMP_CHECKSUM_EN
         sum_acc      <= '0;
         dump_sum_o   <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (start_i) begin
                  end_addr <= last_reg_i;
                  busy_o   <= 1'b1;
                  state    <= READ;
`ifdef REGFILE_DUMP_CHECKSUM_EN
                  sum_acc  <= '0;
`endif
               end
            end
            READ: begin
               dump_data_o  <= rf_read_data_i;
               dump_addr_o  <= cur_addr;
               dump_valid_o <= 1'b1;
`ifdef REGFILE_DUMP_CHECKSUM_EN
               dump_last_o  <= 1'b0;
`else
               dump_last_o  <= at_end;
`endif
               state        <= SEND;
            end
            SEND: begin
               if (dump_ready_i) begin
                  dump_valid_o <= 1'b0;
                  dump_last_o  <= 1'b0;
                  if (!at_end) begin
                     state <= READ;
                  end else begin
`ifdef REGFILE_DUMP_CHECKSUM_EN
                     // Checksum beat folds in the register beat being accepted right now.
                     dump_valid_o <= 1'b1;
                     dump_data_o  <= sum_acc ^ dump_data_o;
                     dump_addr_o  <= end_addr;
                     dump_last_o  <= 1'b1;
                     dump_sum_o   <= 1'b1;
                     state        <= SUM;
`else
                     done_o <= 1'b1;
                     state  <= DONE;
`endif
                  end
`ifdef REGFILE_DUMP_CHECKSUM_EN
                  sum_acc <= sum_acc ^ dump_data_o;
`endif
               end
            end
`ifdef REGFILE_DUMP_CHECKSUM_EN
            SUM: begin
               if (dump_ready_i) begin
                  dump_valid_o <= 1'b0;
                  dump_last_o  <= 1'b0;
                  dump_sum_o   <= 1'b0;
                  done_o       <= 1'b1;
                  state        <= DONE;
               end
            end
`endif
            DONE: begin
               done_o <= 1'b0;
               busy_o <= 1'b0;
               state  <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_regfile_dump_reader.sv
// tb/tb_regfile_dump_reader.sv - directed self-checking bench for regfile_dump_reader
module tb_regfile_dump_reader;

   logic        clk = 1'b0;
   logic        reset;
   logic        start_i;
   logic [4:0]  first_reg_i;
   logic [4:0]  last_reg_i;
   logic [4:0]  rf_read_addr_o;
   logic [31:0] rf_read_data_i;
   logic        dump_valid_o;
   logic        dump_ready_i;
   logic [4:0]  dump_addr_o;
   logic [31:0] dump_data_o;
   logic        dump_last_o;
   logic        busy_o;
   logic        done_o;
`ifdef REGFILE_DUMP_CHECKSUM_EN
   logic        dump_sum_o;
   localparam int CS = 1;
`else
   localparam int CS = 0;
`endif

   logic [31:0] rf [32];
   assign rf_read_data_i = rf[rf_read_addr_o];

   always #5 clk = ~clk;

   regfile_dump_reader dut (
      .clk            (clk),
      .reset          (reset),
      .start_i        (start_i),
      .first_reg_i    (first_reg_i),
      .last_reg_i     (last_reg_i),
      .rf_read_addr_o (rf_read_addr_o),
      .rf_read_data_i (rf_read_data_i),
      .dump_valid_o   (dump_valid_o),
      .dump_ready_i   (dump_ready_i),
      .dump_addr_o    (dump_addr_o),
      .dump_data_o    (dump_data_o),
      .dump_last_o    (dump_last_o),
      .busy_o         (busy_o),
      .done_o         (done_o)
`ifdef REGFILE_DUMP_CHECKSUM_EN
      ,.dump_sum_o    (dump_sum_o)
`endif
   );

   int n_cmp = 0;
   int n_bad = 0;

   int          b_addr[$];
   logic [31:0] b_data[$];
   bit          b_last[$];
   bit          b_sum[$];
   int          first_idx, last_idx, done_idx, busy_cnt;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic start_dump(input logic [4:0] f, input logic [4:0] l);
      start_i     = 1'b1;
      first_reg_i = f;
      last_reg_i  = l;
      step();
      start_i     = 1'b0;
   endtask

   // Samples index 0 is the cycle right after start was taken.
   task automatic collect(input int budget);
      b_addr.delete(); b_data.delete(); b_last.delete(); b_sum.delete();
      first_idx = -1; last_idx = -1; done_idx = -1; busy_cnt = 0;
      for (int i = 0; i < budget; i++) begin
         if (busy_o) busy_cnt++;
         if (dump_valid_o && dump_ready_i) begin
            if (first_idx < 0) first_idx = i;
            last_idx = i;
            b_addr.push_back(int'(dump_addr_o));
            b_data.push_back(dump_data_o);
            b_last.push_back(dump_last_o);
`ifdef REGFILE_DUMP_CHECKSUM_EN
            b_sum.push_back(dump_sum_o);
`else
            b_sum.push_back(1'b0);
`endif
         end
         if (done_o) begin
            done_idx = i;
            break;
         end
         step();
      end
      check("done_seen", done_idx >= 0, 1);
   endtask

   initial begin
      logic [31:0] t1_data [10];
      int          t1_addr;
      bit          found, stable, quiet;

      t1_data = '{32'd88, 32'd77, 32'd20, 32'd66, 32'd78, 32'd30, 32'd15, 32'd27, 32'd61, 32'd89};
      for (int i = 0; i < 32; i++) rf[i] = 32'h0;
      for (int i = 0; i < 10; i++) rf[i+1] = t1_data[i];
      reset = 1'b0; start_i = 1'b0; first_reg_i = '0; last_reg_i = '0; dump_ready_i = 1'b1;

      #12;
      check("rst_valid", dump_valid_o, 0);
      check("rst_busy", busy_o, 0);
      check("rst_done", done_o, 0);
      check("rst_data", dump_data_o, 0);
      check("rst_rdaddr", rf_read_addr_o, 0);
      step();
      reset = 1'b1;
      step();

      // Range 1..10, ready high
      start_dump(5'd1, 5'd10);
      check("t1_rdaddr_read", rf_read_addr_o, 1);
      collect(100);
      check("t1_first_latency", first_idx, 1);
      check("t1_beats", b_addr.size(), 10 + CS);
      for (int i = 0; i < 10 && i < b_addr.size(); i++) begin
         check($sformatf("t1_addr%0d", i), b_addr[i], i + 1);
         check($sformatf("t1_data%0d", i), b_data[i], t1_data[i]);
         check($sformatf("t1_last%0d", i), b_last[i], (i == 9 && CS == 0) ? 1 : 0);
      end
      check("t1_done_latency", done_idx, last_idx + 1);
      check("t1_rate", last_idx, 19 + CS);
      step();
      check("t1_busy_clear", busy_o, 0);
      check("t1_done_pulse", done_o, 0);

      // Single-register range
      step();
      start_dump(5'd5, 5'd5);
      collect(50);
      check("t2_beats", b_addr.size(), 1 + CS);
      check("t2_addr", b_addr[0], 5);
      check("t2_data", b_data[0], 78);
      check("t2_last", b_last[b_last.size()-1], 1);
      check("t2_busy_cycles", busy_cnt, 3 + CS);

      // Wrapping range 30..1
      rf[30] = 32'hAAAA_0000; rf[31] = 32'h0000_5555; rf[0] = 32'h0; rf[1] = 32'd88;
      step(); step();
      start_dump(5'd30, 5'd1);
      collect(100);
      check("t3_beats", b_addr.size(), 4 + CS);
      check("t3_addr0", b_addr[0], 30);
      check("t3_addr1", b_addr[1], 31);
      check("t3_addr2", b_addr[2], 0);
      check("t3_addr3", b_addr[3], 1);
      check("t3_data0", b_data[0], 32'hAAAA_0000);
      check("t3_data1", b_data[1], 32'h0000_5555);
      check("t3_data2", b_data[2], 32'h0);
      check("t3_data3", b_data[3], 32'd88);

      // Backpressure on beat addr 3
      step(); step();
      start_dump(5'd2, 5'd5);
      found = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (dump_valid_o && dump_addr_o == 5'd3) begin
            found = 1'b1;
            break;
         end
         step();
      end
      check("t4_reach_addr3", found, 1);
      dump_ready_i = 1'b0;
      stable = 1'b1;
      for (int i = 0; i < 7; i++) begin
         step();
         if (!(dump_valid_o === 1'b1 && dump_addr_o === 5'd3 && dump_data_o === 32'd20)) stable = 1'b0;
      end
      check("t4_hold_stable", stable, 1);
      dump_ready_i = 1'b1;
      step();
      check("t4_gap_valid", dump_valid_o, 0);
      step();
      check("t4_next_valid", dump_valid_o, 1);
      check("t4_next_addr", dump_addr_o, 4);
      check("t4_next_data", dump_data_o, 66);
      collect(50);
      check("t4_tail_beats", b_addr.size(), 2 + CS);
      check("t4_tail_addr", b_addr[1], 5);

      // Dropped second start, then reset on the third beat
      step(); step();
      start_dump(5'd0, 5'd9);
      step();
      start_i = 1'b1; first_reg_i = 5'd20; last_reg_i = 5'd20;
      step();
      start_i = 1'b0;
      step(); step(); step();
      check("t5_third_valid", dump_valid_o, 1);
      check("t5_third_addr", dump_addr_o, 2);
      reset = 1'b0;
      #1;
      check("t5_rst_valid", dump_valid_o, 0);
      check("t5_rst_busy", busy_o, 0);
      check("t5_rst_addr", dump_addr_o, 0);
      check("t5_rst_data", dump_data_o, 0);
      check("t5_rst_last", dump_last_o, 0);
      check("t5_rst_done", done_o, 0);
      step();
      reset = 1'b1;
      quiet = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step();
         if (done_o !== 1'b0 || busy_o !== 1'b0 || dump_valid_o !== 1'b0) quiet = 1'b0;
      end
      check("t5_quiet_after_rst", quiet, 1);
      start_dump(5'd7, 5'd8);
      collect(50);
      check("t5_fresh_beats", b_addr.size(), 2 + CS);
      check("t5_fresh_addr0", b_addr[0], 7);
      check("t5_fresh_data1", b_data[1], 27);

`ifdef REGFILE_DUMP_CHECKSUM_EN
      step(); step();
      start_dump(5'd1, 5'd2);
      collect(50);
      check("cs_beats", b_addr.size(), 3);
      check("cs_data", b_data[2], 32'h15);
      check("cs_sum_flag", b_sum[2], 1);
      check("cs_last", b_last[2], 1);
      check("cs_addr", b_addr[2], 2);
      check("cs_reg_last0", b_last[0], 0);
      check("cs_reg_last1", b_last[1], 0);
      check("cs_reg_sum0", b_sum[0], 0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
